// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared types and constants for the multiply sequencer slice.
//   mul_op_t        : multiply-class opcodes issued by the EX stage
//   mul_state_t     : sequencer FSM states
//   MUL_LAT_DEFAULT : default latency of the external multiplier core
//   opIsSigned      : true for opcodes that treat operands as two's complement
//   opIsLegal       : false for the one unused opcode encoding (7)
// ---------------------------------------------------------------------------
package mul_pkg;

  typedef enum logic [2:0] {
    MOP_MULT  = 3'd0,
    MOP_MULTU = 3'd1,
    MOP_MADD  = 3'd2,
    MOP_MADDU = 3'd3,
    MOP_MSUB  = 3'd4,
    MOP_MSUBU = 3'd5,
    MOP_MUL   = 3'd6
  } mul_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  localparam int unsigned MUL_LAT_DEFAULT = 6;

  // Signed flavours strip the sign before the unsigned core and restore it
  // on the product afterwards.
  function automatic logic opIsSigned(input logic [2:0] op);
    logic result;
    result = 1'b0;
    case (op)
      3'd0, 3'd2, 3'd4, 3'd6: result = 1'b1;
      default:                result = 1'b0;
    endcase
    return result;
  endfunction

  function automatic logic opIsLegal(input logic [2:0] op);
    return (op != 3'd7);
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// ---------------------------------------------------------------------------
// mul_sign_fix
// Combinational conditional two's-complement negate of a W-bit value.
// With neg_i tied to the operand's sign bit it yields the magnitude of a
// 32-bit operand (0x80000000 maps to itself, which the unsigned core then
// reads as 2^31). With neg_i set to the product sign it restores the sign
// of a 64-bit product.
//   val_i : input value
//   neg_i : 1 = negate, 0 = pass through
//   val_o : result, modulo 2^W
// ---------------------------------------------------------------------------
module mul_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? ((~val_i) + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/mul_sequencer.sv
// ---------------------------------------------------------------------------
// mul_sequencer
// Sequences MIPS multiply-class ops through an external unsigned,
// fixed-latency multiplier core: strips operand signs, waits out the core
// latency, restores the sign, applies HI/LO accumulate/subtract and emits a
// one-cycle write strobe to HI/LO or the GPR file. Stalls IF..EX while the
// op is in flight and drops back to idle on a flush.
//   clk, rst            : clock, async active-high reset
//   op_valid, op_code   : multiply-class op held by EX (stable while stalled)
//   op_a, op_b          : rs / rt operands
//   hilo_in             : forwarded {HI,LO}, sampled only at issue
//   flush               : pipeline flush, aborts any op in progress
//   stall, busy         : pipeline freeze / sequencer not idle
//   core_a, core_b      : registered operand magnitudes to the core
//   core_p              : unsigned core product
//   hilo_we, hilo_wdata : HI/LO write strobe and data
//   gpr_we, gpr_wdata   : GPR write strobe and data (MUL only)
// ---------------------------------------------------------------------------
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [63:0] hilo_in,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic [63:0] core_p,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata,
  output logic        gpr_we,
  output logic [31:0] gpr_wdata
);

  localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

  mul_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mul_op_t          op_q, op_d;
  logic             neg_q, neg_d;
  logic [63:0]      acc_q, acc_d;
  logic [63:0]      prod_q, prod_d;
  logic [31:0]      core_a_q, core_a_d;
  logic [31:0]      core_b_q, core_b_d;

  logic             opSigned;
  logic             opLegal;
  logic             issue;
  logic [31:0]      magA;
  logic [31:0]      magB;
  logic [63:0]      prodSigned;

  assign opSigned = opIsSigned(op_code);
  assign opLegal  = opIsLegal(op_code);
  assign issue    = (state_q == ST_IDLE) && op_valid && opLegal && !flush;

  mul_sign_fix #(.W(32)) u_fix_a (
    .val_i (op_a),
    .neg_i (opSigned & op_a[31]),
    .val_o (magA)
  );

  mul_sign_fix #(.W(32)) u_fix_b (
    .val_i (op_b),
    .neg_i (opSigned & op_b[31]),
    .val_o (magB)
  );

  mul_sign_fix #(.W(64)) u_fix_p (
    .val_i (core_p),
    .neg_i (neg_q),
    .val_o (prodSigned)
  );

  // State register plus every datapath register. Reset is asynchronous so a
  // mid-operation reset clears the outputs immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= MOP_MULT;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      prod_q   <= '0;
      core_a_q <= '0;
      core_b_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      core_a_q <= core_a_d;
      core_b_q <= core_b_d;
    end
  end

  // Next-state logic. Issue captures everything the op needs so EX may keep
  // stalling without the sequencer re-reading it; the core operands then hold
  // until the next issue. The product is captured on the last latency cycle,
  // when the core output is guaranteed settled.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    core_a_d = core_a_q;
    core_b_d = core_b_q;

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          op_d     = mul_op_t'(op_code);
          neg_d    = opSigned & (op_a[31] ^ op_b[31]);
          acc_d    = hilo_in;
          core_a_d = magA;
          core_b_d = magB;
          cnt_d    = CNT_W'(MUL_LAT);
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            prod_d  = prodSigned;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode. Write strobes live only in DONE and a flush arriving in
  // that same cycle still cancels them; write data reads zero elsewhere.
  always_comb begin
    stall      = issue || (state_q == ST_RUN);
    busy       = (state_q != ST_IDLE);
    hilo_we    = 1'b0;
    hilo_wdata = '0;
    gpr_we     = 1'b0;
    gpr_wdata  = '0;

    if (state_q == ST_DONE) begin
      case (op_q)
        MOP_MULT, MOP_MULTU: begin
          hilo_wdata = prod_q;
          hilo_we    = !flush;
        end
        MOP_MADD, MOP_MADDU: begin
          hilo_wdata = acc_q + prod_q;
          hilo_we    = !flush;
        end
        MOP_MSUB, MOP_MSUBU: begin
          hilo_wdata = acc_q - prod_q;
          hilo_we    = !flush;
        end
        MOP_MUL: begin
          gpr_wdata = prod_q[31:0];
          gpr_we    = !flush;
        end
        default: begin
          hilo_we = 1'b0;
        end
      endcase
    end
  end

  assign core_a = core_a_q;
  assign core_b = core_b_q;

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Sequencer between the EX stage and the unsigned fixed-latency multiplier core. Executes MIPS multiply-class ops (MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MUL):
- reduces signed operands to magnitudes, issues them to the core and counts out its latency;
- re-applies the sign and performs HI/LO accumulate/subtract;
- writes HI/LO or the GPR result;
- holds the pipeline stalled until the result is written, and aborts cleanly on flush.

## Interface
Parameters:
- MUL_LAT, default 6: cycles from a core operand register update to a valid core_p (≥1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- op_valid  in  1  EX holds a multiply-class op; held stable while stall=1
- op_code  in  3  mul_op_t
- op_a, op_b  in  32  rs / rt operands
- hilo_in  in  64  current {HI,LO}, already forwarded
- flush  in  1  pipeline flush (exception/eret)
- stall  out  1  freeze IF..EX
- busy  out  1  state ≠ IDLE
- core_a, core_b  out  32  registered magnitudes to the multiplier core
- core_p  in  64  unsigned core product
- hilo_we  out  1  one-cycle HI/LO write strobe
- hilo_wdata  out  64  {HI,LO}
- gpr_we  out  1  one-cycle GPR write strobe (MUL only)
- gpr_wdata  out  32  MUL result

## Operation
FSM states: IDLE, RUN, DONE.

IDLE
- On op_valid && !flush && op_code legal, at the clock edge:
  - latch op_code and the neg flag;
  - snapshot hilo_in into acc;
  - load core_a/core_b with operand magnitudes;
  - counter ← MUL_LAT; go to RUN.
- Signed ops (MULT, MADD, MSUB, MUL): magnitude = a[31] ? −a : a (0x80000000 stays 0x80000000); neg = a[31]^b[31]. Unsigned ops: neg = 0.
- op_code 7 is illegal: ignored, no stall.

RUN
- counter decrements each cycle.
- At the edge where counter==1: prod ← neg ? −core_p : core_p (64-bit two's complement); go to DONE.

DONE (exactly one cycle, stall=0), result by op:
- MULT/MULTU: hilo_wdata = prod.
- MADD/MADDU: hilo_wdata = acc + prod, mod 2^64.
- MSUB/MSUBU: hilo_wdata = acc − prod, mod 2^64.
- MUL: gpr_wdata = prod[31:0], gpr_we = 1; HI/LO untouched.
- Next state is IDLE.

Strobes and flush
- hilo_we/gpr_we are combinational in DONE, qualified by !flush.
- flush in any state → IDLE next edge, no write strobe. A flush in DONE suppresses the strobe in that same cycle.
- stall = (IDLE && op_valid && legal && !flush) || RUN.

## Timing
- Reset values: state IDLE, counter 0; stall, busy, hilo_we, gpr_we = 0; core_a, core_b, hilo_wdata, gpr_wdata, acc, prod = 0. Reset takes effect immediately, mid-operation included.
- Op first presented in cycle 0:
  - stall is high in cycles 0..MUL_LAT;
  - DONE and the write strobe occur in cycle MUL_LAT+1.
  - With MUL_LAT=6: 7 stall cycles, write in cycle 7.
- EX advances at the end of DONE. A back-to-back op is seen in IDLE in cycle MUL_LAT+2; there is no dead cycle beyond that.
- hilo_in is sampled only at issue. Later HI/LO changes during RUN are not observed; the upstream pipeline is stalled, so none occur.
- busy is high in RUN and DONE.
- core_a/core_b hold their values until the next issue.

## Structure
- Package mul_pkg holds:
  - typedef enum logic [2:0] mul_op_t: MOP_MULT=0, MOP_MULTU=1, MOP_MADD=2, MOP_MADDU=3, MOP_MSUB=4, MOP_MSUBU=5, MOP_MUL=6;
  - the state enum;
  - MUL_LAT_DEFAULT = 6.
- Sub-module mul_sign_fix: combinational 32-bit magnitude plus 64-bit conditional negate. Instantiated for operands and product.
- The multiplier core stays outside this block.

## Test plan
All scenarios use a bench core model with a MUL_LAT-stage pipeline. Cycles are counted from the cycle the op is first presented (cycle 0).

- MULTU 0xFFFFFFFF×0xFFFFFFFF → hilo_we in cycle 7, hilo_wdata 0xFFFFFFFE_00000001; stall high in cycles 0–6 only.
- MULT 0xFFFFFFFB×0x00000003 → 0xFFFFFFFF_FFFFFFF1. MULT 0x80000000×0x80000000 → 0x40000000_00000000; core_a = core_b = 0x80000000.
- MADD, hilo_in=0x00000000_00000010, a=0xFFFFFFFE, b=4 → 0x00000000_00000008. MSUBU, hilo_in=0, a=b=1 → 0xFFFFFFFF_FFFFFFFF.
- MUL 0x00010000×0x00010000 → gpr_we=1, gpr_wdata=0, hilo_we=0. Immediately followed by MULT 2×3 → second write in cycle 15, value 0x00000000_00000006.
- flush in cycle 3 → no strobe ever; stall=0 from cycle 4; busy low at cycle 4. flush in DONE cycle → strobe suppressed.
- rst asserted asynchronously mid-RUN (between edges) → stall, busy and core_a drop to 0 before the next edge. After release, a new MULTU 2×2 yields 4.
